// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: circular buffer of {inst, pc}
// with valid/ready output, skid-based fetch stall, one-cycle kill flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int SKID  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         kill,
    input  logic                         in_valid,
    input  logic [XLEN-1:0]              in_inst,
    input  logic [XLEN-1:0]              in_pc,
    output logic                         stall_fetch,
    output logic                         out_valid,
    output logic [XLEN-1:0]              out_inst,
    output logic [XLEN-1:0]              out_pc,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
            $error("fetch_queue: DEPTH must be a power of two >= 2");
        if (SKID < 1 || SKID >= DEPTH)
            $error("fetch_queue: SKID must satisfy 1 <= SKID < DEPTH");
    endgenerate

    logic [XLEN-1:0] r_inst [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_ready && !kill;
    assign w_push  = in_valid && (!w_full || w_pop) && !kill;
    assign w_drop  = in_valid && w_full && !w_pop && !kill;

    // Storage is not reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_tail] <= in_inst;
            r_pc[r_tail]   <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (kill) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + PW'(1);
            if (w_pop)
                r_head <= r_head + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end

    // Outputs depend on registered state only.
    always_comb begin
        out_valid   = !w_empty;
        out_inst    = '0;
        out_pc      = '0;
        if (!w_empty) begin
            out_inst = r_inst[r_head];
            out_pc   = r_pc[r_head];
        end
        stall_fetch = (r_count >= CW'(DEPTH - SKID));
        count       = r_count;
        overflow    = r_overflow;
    end

endmodule
